// File: rtl/muldiv_issue_ctrl.sv
// Issue controller for the M-extension MULDIV unit: hands one decoded M instruction
// to MULDIV, waits out the multiply latency or the divide busy window, and presents the result.
//
// state      | meaning
// S_IDLE     | ready for a request once MULDIV is quiet
// S_ISSUE    | start pulse to MULDIV, pick the wait path
// S_MUL_WAIT | counting down the fixed multiplier latency
// S_DIV_WAIT | polling MULDIV busy under a watchdog
// S_DONE     | result held for writeback handshake
module muldiv_issue_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int MUL_LATENCY = 1,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [2:0]            req_funct3_i,
  input  logic [DATA_WIDTH-1:0] req_rs1_i,
  input  logic [DATA_WIDTH-1:0] req_rs2_i,
  input  logic [4:0]            req_rd_i,
  output logic [DATA_WIDTH-1:0] md_rs1_o,
  output logic [DATA_WIDTH-1:0] md_rs2_o,
  output logic [2:0]            md_funct3_o,
  output logic                  md_start_o,
  input  logic                  md_busy_i,
  input  logic [DATA_WIDTH-1:0] md_c_i,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic [4:0]            wb_rd_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  output logic                  err_o
);

  localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY + 1) : 1;
  localparam int WD_W  = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_MUL_WAIT,
    S_DIV_WAIT,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] md_rs1_q, md_rs1_d;
  logic [DATA_WIDTH-1:0] md_rs2_q, md_rs2_d;
  logic [2:0]            md_funct3_q, md_funct3_d;
  logic [4:0]            rd_q, rd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic                  err_q, err_d;

  assign req_ready_o = (state_q == S_IDLE) & ~md_busy_i & ~rst;
  assign md_start_o  = (state_q == S_ISSUE);
  assign wb_valid_o  = (state_q == S_DONE);
  assign md_rs1_o    = md_rs1_q;
  assign md_rs2_o    = md_rs2_q;
  assign md_funct3_o = md_funct3_q;
  assign wb_rd_o     = rd_q;
  assign wb_data_o   = wb_data_q;
  assign err_o       = err_q;

  always_comb begin
    state_d     = state_q;
    md_rs1_d    = md_rs1_q;
    md_rs2_d    = md_rs2_q;
    md_funct3_d = md_funct3_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    wd_d        = wd_q;
    wb_data_d   = wb_data_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i && req_ready_o) begin
          md_rs1_d    = req_rs1_i;
          md_rs2_d    = req_rs2_i;
          md_funct3_d = req_funct3_i;
          rd_d        = req_rd_i;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!md_funct3_q[2]) begin
          if (MUL_LATENCY == 0) begin
            wb_data_d = md_c_i;
            state_d   = S_DONE;
          end else begin
            cnt_d   = CNT_W'(MUL_LATENCY);
            state_d = S_MUL_WAIT;
          end
        end else if (!md_busy_i) begin
          // divide-by-zero, overflow and fused remainder finish without busy
          wb_data_d = md_c_i;
          state_d   = S_DONE;
        end else begin
          wd_d    = '0;
          state_d = S_DIV_WAIT;
        end
      end
      S_MUL_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          wb_data_d = md_c_i;
          state_d   = S_DONE;
        end
      end
      S_DIV_WAIT: begin
        if (!md_busy_i) begin
          wb_data_d = md_c_i;
          state_d   = S_DONE;
        end else begin
          wd_d = wd_q + WD_W'(1);
          if (wd_q == WD_W'(DIV_TIMEOUT - 1)) begin
            err_d     = 1'b1;
            wb_data_d = '1;
            state_d   = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (wb_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      md_rs1_q    <= '0;
      md_rs2_q    <= '0;
      md_funct3_q <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      wd_q        <= '0;
      wb_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      md_rs1_q    <= md_rs1_d;
      md_rs2_q    <= md_rs2_d;
      md_funct3_q <= md_funct3_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      wd_q        <= wd_d;
      wb_data_q   <= wb_data_d;
      err_q       <= err_d;
    end
  end

endmodule
